connection_block_cfgld: RTL and testbench
=========================================

Name: connection_block_cfgld

Overview:
- Parametrised successor to the unidirectional connection block. It routes single, double and global tracks into two facing CLBs. It drives CLB outputs onto selected single and double tracks, and passes carry between the CLBs.
- New in this generation: a word-wide streaming configuration loader with valid/ready handshake, double-buffered shadow and active configuration, atomic commit, abort, and a load-progress counter.
- Sits between the two CLBs of a tile. The configuration controller's word stream is daisy-fed to each tile.

Parameters:
- WS, 4, single tracks per direction.
- WD, 4, double tracks per direction; must be even.
- WG, 2, global lines.
- CLBIN, 4, inputs per CLB.
- CLBOUT, 1, outputs per CLB.
- CLBOS, 1, single tracks per direction drivable by CLB outputs; 1..WS.
- CLBOS_BIAS, 0, single track offset.
- CLBOD, 1, double tracks per direction drivable by CLB outputs; 1..WD/2.
- CLBOD_BIAS, 0, double track offset.
- CLBX, 1, when 1 each CLB input may also select the facing CLB's outputs.
- CFG_W, 8, configuration word width.
- SEL_IN, clog2(2*(WS+WD)+WG+CLBX*CLBOUT), input-mux select width (5 at defaults).
- SEL_OUT, clog2(2*CLBOUT+1), output-mux select width (2 at defaults).
- CONF_WIDTH, 2*SEL_OUT*(CLBOS+CLBOD)+2*CLBIN*SEL_IN, configuration width (48 at defaults).
- NBEATS, ceil(CONF_WIDTH/CFG_W), words per full load (6 at defaults).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- single0_in, single1_in  in  WS  incoming singles.
- single0_out, single1_out  out  WS  outgoing singles.
- double0_in, double1_in  in  WD  incoming doubles.
- double0_out, double1_out  out  WD  outgoing doubles.
- global  in  WG  global lines.
- clb0_output, clb1_output  in  CLBOUT  CLB outputs.
- clb0_cout, clb1_cout  in  1  carry out.
- clb0_input, clb1_input  out  CLBIN  CLB inputs.
- clb0_cin, clb1_cin  out  1  carry in.
- cfg_data  in  CFG_W  configuration word.
- cfg_valid  in  1  word valid.
- cfg_ready  out  1  loader can accept a word.
- cfg_abort  in  1  discard a partial load.
- cfg_done  out  1  one-cycle pulse when the new configuration is active.
- cfg_beat  out  clog2(NBEATS+1)  words accepted in the current load.

Behaviour:
- Reset:
  - Active and shadow registers cleared to 0.
  - Loader state IDLE; cfg_beat=0, cfg_done=0, cfg_ready=1 in the cycle after reset deasserts.
  - Routing with all-zero config: every track is passthrough, and every CLB input equals single0_in-side track 0 after muxing.
- Carry: clb1_cin=clb0_cout and clb0_cin=clb1_cout, combinational.
- Output muxes:
  - For k<CLBOS, track t=(k+CLBOS_BIAS*CLBOS)%WS. Muxed single0[t] = sel 0 ? single0_in[t] : sel 1..CLBOUT ? clb0_output[sel-1] : sel CLBOUT+1..2*CLBOUT ? clb1_output[sel-CLBOUT-1] : single0_in[t] (out-of-range). single1 is handled identically.
  - Doubles use the same rule with t=(k+CLBOD_BIAS*CLBOD)%(WD/2). Double tracks at index >= WD/2 are always passthrough.
  - Crossover: single0_out=muxed single1, single1_out=muxed single0; doubles likewise.
- Input muxes:
  - Candidate index order: 0..WS-1 muxed single0; then muxed single1, muxed double0, muxed double1, global; then (if CLBX) the facing CLB's outputs.
  - A select value beyond the candidate count drives 0.
- Active config field layout, LSB first:
  - single0 out selects, then single1, double0, double1 (SEL_OUT each, CLBOS or CLBOD entries per group);
  - then clb0 input selects, then clb1 input selects (SEL_IN each).
- Loader FSM:
  - IDLE/LOAD: cfg_ready=1. A word is accepted on cfg_valid&&cfg_ready. Word number cfg_beat writes shadow[cfg_beat*CFG_W +: CFG_W]; bits at or above CONF_WIDTH are dropped. cfg_beat then increments. State is LOAD while 0<cfg_beat<NBEATS.
  - Accepting word NBEATS-1 goes to COMMIT.
  - COMMIT: cfg_ready=0, and this state lasts exactly one cycle. At the end of that cycle active<=shadow and cfg_beat<=0. The next cycle is IDLE with cfg_done=1.
  - Latency: last word accepted in cycle t → new routing visible and cfg_done=1 in cycle t+2.
- Abort:
  - In IDLE/LOAD, cfg_abort clears cfg_beat to 0 and returns to IDLE. Shadow content is don't-care and active is unchanged.
  - Abort in the same cycle as the last word: abort wins, and no commit occurs.
  - Abort during COMMIT is ignored; commit is atomic.
- Active configuration changes only at commit, so routing is glitch-free during a load.
- Reset mid-load or during COMMIT returns the block to the full reset state above.

Test Plan:
- Reset, then drive single1_in=4'hA, double0_in=4'h5 → single0_out=4'hA, double1_out=4'h5, cfg_ready=1, cfg_beat=0, every clb0_input bit = single0_in[0].
- Stream 6 words with single0 track-0 select=1 and clb0 input 0 select=16 (global[0]), with valid held high → cfg_ready low exactly 1 cycle, cfg_done pulse 2 cycles after the last word. Then single1_out[0] follows clb0_output[0] and clb0_input[0] follows global[0].
- Toggle cfg_valid randomly while streaming → the result is identical to the back-to-back load, and cfg_beat counts 0..5.
- After 3 words assert cfg_abort → cfg_beat=0, routing unchanged, no cfg_done. A following full load commits correctly.
- Assert abort together with the 6th word → no commit. Assert rst in the COMMIT cycle → active=0 and passthrough routing.
- Program clb1 input 0 select=18 (CLBX) and select=31 (out-of-range) → the input follows clb0_output[0] for select 18 and is 0 for select 31. Both carry crossovers are checked.

Source files
------------

// File: rtl/connection_block_cfgld.sv
// Connection block between two facing CLBs: routes single, double and global
// tracks into the CLB inputs, lets CLB outputs drive selected tracks, and
// crosses the carry chain. Routing is set by an active configuration that is
// loaded word by word into a shadow copy and committed atomically.
module connection_block_cfgld #(
  parameter int WS         = 4,
  parameter int WD         = 4,
  parameter int WG         = 2,
  parameter int CLBIN      = 4,
  parameter int CLBOUT     = 1,
  parameter int CLBOS      = 1,
  parameter int CLBOS_BIAS = 0,
  parameter int CLBOD      = 1,
  parameter int CLBOD_BIAS = 0,
  parameter int CLBX       = 1,
  parameter int CFG_W      = 8,
  localparam int NCAND      = 2*(WS+WD) + WG + CLBX*CLBOUT,
  localparam int SEL_IN     = $clog2(NCAND),
  localparam int SEL_OUT    = $clog2(2*CLBOUT + 1),
  localparam int CONF_WIDTH = 2*SEL_OUT*(CLBOS+CLBOD) + 2*CLBIN*SEL_IN,
  localparam int NBEATS     = (CONF_WIDTH + CFG_W - 1) / CFG_W,
  localparam int BEAT_W     = $clog2(NBEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WS-1:0]     single0_in,
  input  logic [WS-1:0]     single1_in,
  output logic [WS-1:0]     single0_out,
  output logic [WS-1:0]     single1_out,
  input  logic [WD-1:0]     double0_in,
  input  logic [WD-1:0]     double1_in,
  output logic [WD-1:0]     double0_out,
  output logic [WD-1:0]     double1_out,
  input  logic [WG-1:0]     global,
  input  logic [CLBOUT-1:0] clb0_output,
  input  logic [CLBOUT-1:0] clb1_output,
  input  logic              clb0_cout,
  input  logic              clb1_cout,
  output logic [CLBIN-1:0]  clb0_input,
  output logic [CLBIN-1:0]  clb1_input,
  output logic              clb0_cin,
  output logic              clb1_cin,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_abort,
  output logic              cfg_done,
  output logic [BEAT_W-1:0] cfg_beat
);

  // Bit offsets of each select group inside the active configuration.
  localparam int S0_OFF  = 0;
  localparam int S1_OFF  = S0_OFF + CLBOS*SEL_OUT;
  localparam int D0_OFF  = S1_OFF + CLBOS*SEL_OUT;
  localparam int D1_OFF  = D0_OFF + CLBOD*SEL_OUT;
  localparam int IN0_OFF = D1_OFF + CLBOD*SEL_OUT;
  localparam int IN1_OFF = IN0_OFF + CLBIN*SEL_IN;
  localparam int XBASE   = 2*(WS+WD) + WG;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_e;

  state_e                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [NBEATS*CFG_W-1:0]   shadow_q, shadow_d;
  logic [CONF_WIDTH-1:0]     active_q, active_d;
  logic                      ready_q, ready_d;
  logic                      done_q, done_d;

  logic [WS-1:0]             ms0, ms1;
  logic [WD-1:0]             md0, md1;
  logic [NCAND-1:0]          cand_to0, cand_to1;

  // Output-mux choice: 0 and out-of-range keep the track, otherwise a CLB output.
  function automatic logic pick_out(input logic [SEL_OUT-1:0] sel,
                                    input logic               pass,
                                    input logic [CLBOUT-1:0]  o0,
                                    input logic [CLBOUT-1:0]  o1);
    logic r;
    r = pass;
    for (int j = 0; j < CLBOUT; j++) begin
      if (int'(sel) == j + 1)          r = o0[j];
      if (int'(sel) == CLBOUT + 1 + j) r = o1[j];
    end
    return r;
  endfunction

  // Loader next-state: accept words into the shadow, then spend one cycle committing.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (cfg_abort) begin
          beat_d  = '0;
          state_d = IDLE;
        end else if (cfg_valid && ready_q) begin
          for (int b = 0; b < NBEATS; b++) begin
            if (beat_q == BEAT_W'(b)) shadow_d[b*CFG_W +: CFG_W] = cfg_data;
          end
          beat_d  = beat_q + BEAT_W'(1);
          state_d = (beat_q == BEAT_W'(NBEATS-1)) ? COMMIT : LOAD;
        end
      end
      COMMIT: begin
        active_d = shadow_q[CONF_WIDTH-1:0];
        beat_d   = '0;
        state_d  = IDLE;
        done_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != COMMIT);
  end

  // All loader state and its registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      shadow_q <= '0;
      active_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Track output muxes: only the CLB-drivable tracks can be overridden.
  always_comb begin
    ms0 = single0_in;
    ms1 = single1_in;
    md0 = double0_in;
    md1 = double1_in;
    for (int k = 0; k < CLBOS; k++) begin
      ms0[(k+CLBOS_BIAS*CLBOS)%WS] = pick_out(active_q[S0_OFF + k*SEL_OUT +: SEL_OUT],
                                              single0_in[(k+CLBOS_BIAS*CLBOS)%WS],
                                              clb0_output, clb1_output);
      ms1[(k+CLBOS_BIAS*CLBOS)%WS] = pick_out(active_q[S1_OFF + k*SEL_OUT +: SEL_OUT],
                                              single1_in[(k+CLBOS_BIAS*CLBOS)%WS],
                                              clb0_output, clb1_output);
    end
    for (int k = 0; k < CLBOD; k++) begin
      md0[(k+CLBOD_BIAS*CLBOD)%(WD/2)] = pick_out(active_q[D0_OFF + k*SEL_OUT +: SEL_OUT],
                                                  double0_in[(k+CLBOD_BIAS*CLBOD)%(WD/2)],
                                                  clb0_output, clb1_output);
      md1[(k+CLBOD_BIAS*CLBOD)%(WD/2)] = pick_out(active_q[D1_OFF + k*SEL_OUT +: SEL_OUT],
                                                  double1_in[(k+CLBOD_BIAS*CLBOD)%(WD/2)],
                                                  clb0_output, clb1_output);
    end
  end

  // Candidate lists seen by each CLB's input muxes; the tail holds the facing CLB's outputs.
  always_comb begin
    cand_to0 = '0;
    for (int j = 0; j < WS; j++) begin
      cand_to0[j]      = ms0[j];
      cand_to0[WS + j] = ms1[j];
    end
    for (int j = 0; j < WD; j++) begin
      cand_to0[2*WS + j]      = md0[j];
      cand_to0[2*WS + WD + j] = md1[j];
    end
    for (int j = 0; j < WG; j++) begin
      cand_to0[2*WS + 2*WD + j] = global[j];
    end
    cand_to1 = cand_to0;
    for (int j = 0; j < CLBX*CLBOUT; j++) begin
      cand_to0[XBASE + j] = clb1_output[j];
      cand_to1[XBASE + j] = clb0_output[j];
    end
  end

  // CLB input muxes; a select past the candidate list drives 0.
  always_comb begin
    clb0_input = '0;
    clb1_input = '0;
    for (int i = 0; i < CLBIN; i++) begin
      for (int j = 0; j < NCAND; j++) begin
        if (int'(active_q[IN0_OFF + i*SEL_IN +: SEL_IN]) == j) clb0_input[i] = cand_to0[j];
        if (int'(active_q[IN1_OFF + i*SEL_IN +: SEL_IN]) == j) clb1_input[i] = cand_to1[j];
      end
    end
  end

  assign single0_out = ms1;
  assign single1_out = ms0;
  assign double0_out = md1;
  assign double1_out = md0;
  assign clb1_cin    = clb0_cout;
  assign clb0_cin    = clb1_cout;
  assign cfg_ready   = ready_q;
  assign cfg_done    = done_q;
  assign cfg_beat    = beat_q;

endmodule

// File: tb/tb_connection_block_cfgld.sv
// Bench for connection_block_cfgld at default parameters: hand sequences for
// the loader corner cases, a vector table of routing cases, and a randomized
// run checked against a queue-based loader model and a select-table router.
module tb_connection_block_cfgld;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] single0_in, single1_in, single0_out, single1_out;
  logic [3:0] double0_in, double1_in, double0_out, double1_out;
  logic [1:0] glob;
  logic       clb0_output, clb1_output, clb0_cout, clb1_cout;
  logic [3:0] clb0_input, clb1_input;
  logic       clb0_cin, clb1_cin;
  logic [7:0] cfg_data;
  logic       cfg_valid, cfg_ready, cfg_abort, cfg_done;
  logic [2:0] cfg_beat;

  int n_checks = 0;
  int n_fail   = 0;

  // Loader model: accepted words queue, commit pending flag, done pulse, active config.
  logic [7:0]  words[$];
  bit          m_commit;
  bit          m_done;
  logic [47:0] m_active;

  typedef struct packed {
    logic [3:0] s0o, s1o, d0o, d1o, in0, in1;
  } route_t;

  typedef struct {
    logic [47:0] cfg;
    logic [3:0]  s0, s1, d0, d1;
    logic [1:0]  g;
    logic        c0o, c1o;
    logic [3:0]  e_s0o, e_s1o, e_d0o, e_d1o, e_in0, e_in1;
  } vec_t;

  vec_t vecs[4];
  int   rl, dl;

  // Free-running clock.
  always #5 clk = ~clk;

  connection_block_cfgld dut (
    .clk(clk), .rst(rst),
    .single0_in(single0_in), .single1_in(single1_in),
    .single0_out(single0_out), .single1_out(single1_out),
    .double0_in(double0_in), .double1_in(double1_in),
    .double0_out(double0_out), .double1_out(double1_out),
    .global(glob),
    .clb0_output(clb0_output), .clb1_output(clb1_output),
    .clb0_cout(clb0_cout), .clb1_cout(clb1_cout),
    .clb0_input(clb0_input), .clb1_input(clb1_input),
    .clb0_cin(clb0_cin), .clb1_cin(clb1_cin),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_abort(cfg_abort), .cfg_done(cfg_done), .cfg_beat(cfg_beat)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int field(input logic [47:0] a, input int lsb, input int w);
    return int'((a >> lsb) & ((48'd1 << w) - 48'd1));
  endfunction

  function automatic logic [47:0] mkcfg(input int s0, s1, d0, d1, a0, a1, a2, a3, b0, b1, b2, b3);
    logic [47:0] c;
    int ins[8];
    ins = '{a0, a1, a2, a3, b0, b1, b2, b3};
    c = 48'(s0 & 3) | (48'(s1 & 3) << 2) | (48'(d0 & 3) << 4) | (48'(d1 & 3) << 6);
    for (int i = 0; i < 4; i++) begin
      c |= 48'(ins[i] & 31) << (8 + 5*i);
      c |= 48'(ins[4+i] & 31) << (28 + 5*i);
    end
    return c;
  endfunction

  function automatic logic pick(input int sel, input logic pass, input logic o0, input logic o1);
    if (sel == 1) return o0;
    if (sel == 2) return o1;
    return pass;
  endfunction

  function automatic route_t model_route(input logic [47:0] act);
    route_t r;
    logic [3:0] ms0, ms1, md0, md1;
    logic c0[19];
    logic c1[19];
    int s;
    ms0 = single0_in; ms1 = single1_in; md0 = double0_in; md1 = double1_in;
    ms0[0] = pick(field(act, 0, 2), single0_in[0], clb0_output, clb1_output);
    ms1[0] = pick(field(act, 2, 2), single1_in[0], clb0_output, clb1_output);
    md0[0] = pick(field(act, 4, 2), double0_in[0], clb0_output, clb1_output);
    md1[0] = pick(field(act, 6, 2), double1_in[0], clb0_output, clb1_output);
    for (int j = 0; j < 4; j++) begin
      c0[j] = ms0[j]; c0[4+j] = ms1[j]; c0[8+j] = md0[j]; c0[12+j] = md1[j];
    end
    c0[16] = glob[0]; c0[17] = glob[1];
    c1 = c0;
    c0[18] = clb1_output;
    c1[18] = clb0_output;
    for (int i = 0; i < 4; i++) begin
      s = field(act, 8 + 5*i, 5);
      r.in0[i] = (s < 19) ? c0[s] : 1'b0;
      s = field(act, 28 + 5*i, 5);
      r.in1[i] = (s < 19) ? c1[s] : 1'b0;
    end
    r.s0o = ms1; r.s1o = ms0; r.d0o = md1; r.d1o = md0;
    return r;
  endfunction

  task automatic modelClock();
    logic [47:0] a;
    if (rst) begin
      words.delete(); m_commit = 0; m_done = 0; m_active = '0;
    end else if (m_commit) begin
      a = '0;
      for (int b = 0; b < 6; b++) a |= 48'(words[b]) << (8*b);
      m_active = a; words.delete(); m_commit = 0; m_done = 1;
    end else begin
      m_done = 0;
      if (cfg_abort) words.delete();
      else if (cfg_valid) begin
        words.push_back(cfg_data);
        if (words.size() == 6) m_commit = 1;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    route_t r;
    r = model_route(m_active);
    checkOutput({tag, "_ready"}, cfg_ready, !m_commit);
    checkOutput({tag, "_beat"}, cfg_beat, words.size());
    checkOutput({tag, "_done"}, cfg_done, m_done);
    checkOutput({tag, "_single0_out"}, single0_out, r.s0o);
    checkOutput({tag, "_single1_out"}, single1_out, r.s1o);
    checkOutput({tag, "_double0_out"}, double0_out, r.d0o);
    checkOutput({tag, "_double1_out"}, double1_out, r.d1o);
    checkOutput({tag, "_clb0_input"}, clb0_input, r.in0);
    checkOutput({tag, "_clb1_input"}, clb1_input, r.in1);
    checkOutput({tag, "_clb1_cin"}, clb1_cin, clb0_cout);
    checkOutput({tag, "_clb0_cin"}, clb0_cin, clb1_cout);
  endtask

  task automatic step();
    modelClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] s0, s1, d0, d1, input logic [1:0] g, input logic c0o, c1o);
    single0_in = s0; single1_in = s1; double0_in = d0; double1_in = d1;
    glob = g; clb0_output = c0o; clb1_output = c1o;
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1; cfg_valid = 1'b0; cfg_abort = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic loadConfig(input logic [47:0] cfg, input bit rand_valid, output int ready_low, output int done_delay);
    int idx, cyc, last_acc, done_at;
    idx = 0; cyc = 0; last_acc = -1; done_at = -1; ready_low = 0;
    while (done_at < 0 && cyc < 200) begin
      if (idx >= 6) cfg_valid = 1'b0;
      else if (rand_valid) cfg_valid = 1'($urandom_range(0, 1));
      else cfg_valid = 1'b1;
      cfg_data  = (idx < 6) ? cfg[idx*8 +: 8] : 8'($urandom);
      cfg_abort = 1'b0;
      #1;
      if (!cfg_ready) ready_low++;
      if (cfg_done) done_at = cyc;
      if (cfg_valid && cfg_ready) begin
        checkOutput("load_beat", cfg_beat, idx);
        if (idx == 5) last_acc = cyc;
        idx++;
      end
      checkAll("load");
      step();
      cyc++;
    end
    cfg_valid = 1'b0;
    done_delay = (done_at >= 0 && last_acc >= 0) ? done_at - last_acc : -1;
  endtask

  // Hard time limit so a stuck design cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    logic [47:0] cfg_a, cfg_b;
    rst = 1'b1; cfg_valid = 1'b0; cfg_abort = 1'b0; cfg_data = '0;
    clb0_cout = 1'b0; clb1_cout = 1'b0;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0);

    cfg_a = mkcfg(1, 0, 0, 0, 16, 0, 0, 0, 0, 0, 0, 0);
    cfg_b = mkcfg(1, 2, 2, 1, 16, 17, 18, 5, 18, 31, 0, 12);

    vecs[0] = '{48'd0, 4'h6, 4'h9, 4'h3, 4'hC, 2'b10, 1'b1, 1'b0, 4'h9, 4'h6, 4'hC, 4'h3, 4'h0, 4'h0};
    vecs[1] = '{cfg_b, 4'h6, 4'h9, 4'h3, 4'hC, 2'b10, 1'b1, 1'b0, 4'h8, 4'h7, 4'hD, 4'h2, 4'h2, 4'hD};
    vecs[2] = '{cfg_b, 4'h0, 4'hF, 4'hF, 4'h0, 2'b01, 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'hD, 4'h0};
    vecs[3] = '{mkcfg(3, 0, 3, 0, 3, 7, 11, 15, 19, 10, 14, 8),
                4'h8, 4'h0, 4'h4, 4'hB, 2'b11, 1'b1, 1'b1, 4'h0, 4'h8, 4'hB, 4'h4, 4'h9, 4'h2};

    // Reset state and passthrough routing.
    resetDut();
    applyStimulus(4'h1, 4'hA, 4'h5, 4'h0, 2'b00, 1'b0, 1'b0);
    checkOutput("rst_ready", cfg_ready, 1);
    checkOutput("rst_beat", cfg_beat, 0);
    checkOutput("rst_done", cfg_done, 0);
    checkOutput("pass_single0_out", single0_out, 4'hA);
    checkOutput("pass_double1_out", double1_out, 4'h5);
    checkOutput("pass_clb0_input_hi", clb0_input, 4'hF);
    checkAll("t1");
    step();
    applyStimulus(4'hE, 4'hA, 4'h5, 4'h0, 2'b00, 1'b0, 1'b0);
    checkOutput("pass_clb0_input_lo", clb0_input, 4'h0);
    checkOutput("pass_clb1_input_lo", clb1_input, 4'h0);
    step();

    // Back-to-back load of cfg_a.
    loadConfig(cfg_a, 1'b0, rl, dl);
    checkOutput("b2b_ready_low_cycles", rl, 1);
    checkOutput("b2b_done_latency", dl, 2);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 1'b1, 1'b0);
    checkOutput("a_single1_out0_hi", single1_out[0], 1);
    checkOutput("a_clb0_input0_hi", clb0_input[0], 1);
    step();
    applyStimulus(4'hF, 4'hF, 4'h0, 4'h0, 2'b10, 1'b0, 1'b1);
    checkOutput("a_single1_out0_lo", single1_out[0], 0);
    checkOutput("a_clb0_input0_lo", clb0_input[0], 0);
    step();

    // Same configuration with a randomly gapped valid.
    resetDut();
    loadConfig(cfg_a, 1'b1, rl, dl);
    checkOutput("gap_ready_low_cycles", rl, 1);
    checkOutput("gap_done_latency", dl, 2);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 1'b1, 1'b0);
    checkOutput("gap_single1_out0_hi", single1_out[0], 1);
    checkOutput("gap_clb0_input0_hi", clb0_input[0], 1);
    step();
    applyStimulus(4'hF, 4'hF, 4'h0, 4'h0, 2'b10, 1'b0, 1'b1);
    checkOutput("gap_single1_out0_lo", single1_out[0], 0);
    checkOutput("gap_clb0_input0_lo", clb0_input[0], 0);
    step();

    // Abort after three words.
    for (int w = 0; w < 3; w++) begin
      cfg_valid = 1'b1; cfg_data = cfg_b[w*8 +: 8]; #1;
      checkAll("abort3");
      step();
    end
    cfg_valid = 1'b0; #1;
    checkOutput("abort_beat_before", cfg_beat, 3);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0; #1;
    checkOutput("abort_beat_cleared", cfg_beat, 0);
    checkOutput("abort_ready", cfg_ready, 1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 1'b1, 1'b0);
      checkOutput("abort_no_done", cfg_done, 0);
      checkOutput("abort_routing_kept", single1_out[0], 1);
      step();
    end
    loadConfig(cfg_b, 1'b0, rl, dl);
    checkOutput("after_abort_done_latency", dl, 2);
    applyStimulus(4'h6, 4'h9, 4'h3, 4'hC, 2'b10, 1'b1, 1'b0);
    checkOutput("after_abort_clb1_input", clb1_input, 4'hD);
    checkOutput("after_abort_single0_out", single0_out, 4'h8);
    step();

    // Abort together with the last word: nothing commits.
    for (int w = 0; w < 5; w++) begin
      cfg_valid = 1'b1; cfg_data = 8'h00;
      step();
    end
    cfg_valid = 1'b1; cfg_abort = 1'b1; cfg_data = 8'h00;
    step();
    cfg_valid = 1'b0; cfg_abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput("lastabort_no_done", cfg_done, 0);
      checkOutput("lastabort_ready", cfg_ready, 1);
      checkOutput("lastabort_beat", cfg_beat, 0);
      checkAll("lastabort");
      step();
    end
    applyStimulus(4'h6, 4'h9, 4'h3, 4'hC, 2'b10, 1'b1, 1'b0);
    checkOutput("lastabort_active_kept", clb1_input, 4'hD);
    step();

    // Reset during the commit cycle.
    for (int w = 0; w < 6; w++) begin
      cfg_valid = 1'b1; cfg_data = cfg_a[w*8 +: 8];
      step();
    end
    cfg_valid = 1'b0; #1;
    checkOutput("commit_ready_low", cfg_ready, 0);
    checkOutput("commit_beat", cfg_beat, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(4'h1, 4'hA, 4'h5, 4'h0, 2'b00, 1'b1, 1'b1);
    checkOutput("rstcommit_ready", cfg_ready, 1);
    checkOutput("rstcommit_beat", cfg_beat, 0);
    checkOutput("rstcommit_done", cfg_done, 0);
    checkOutput("rstcommit_single0_out", single0_out, 4'hA);
    checkOutput("rstcommit_single1_out", single1_out, 4'h1);
    checkOutput("rstcommit_double1_out", double1_out, 4'h5);
    checkOutput("rstcommit_clb0_input", clb0_input, 4'hF);
    step();
    #1;
    checkOutput("rstcommit_no_late_done", cfg_done, 0);
    checkAll("rstcommit");
    step();

    // Routing vector table.
    for (int v = 0; v < 4; v++) begin
      loadConfig(vecs[v].cfg, 1'b0, rl, dl);
      checkOutput("vec_done_latency", dl, 2);
      applyStimulus(vecs[v].s0, vecs[v].s1, vecs[v].d0, vecs[v].d1, vecs[v].g, vecs[v].c0o, vecs[v].c1o);
      checkOutput("vec_single0_out", single0_out, vecs[v].e_s0o);
      checkOutput("vec_single1_out", single1_out, vecs[v].e_s1o);
      checkOutput("vec_double0_out", double0_out, vecs[v].e_d0o);
      checkOutput("vec_double1_out", double1_out, vecs[v].e_d1o);
      checkOutput("vec_clb0_input", clb0_input, vecs[v].e_in0);
      checkOutput("vec_clb1_input", clb1_input, vecs[v].e_in1);
      checkAll("vec");
      step();
    end

    // Carry crossover in both directions.
    for (int c = 0; c < 4; c++) begin
      clb0_cout = c[0]; clb1_cout = c[1]; #1;
      checkOutput("carry_clb1_cin", clb1_cin, c[0]);
      checkOutput("carry_clb0_cin", clb0_cin, c[1]);
    end
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_abort = ($urandom_range(0, 31) == 0);
      cfg_data  = 8'($urandom);
      clb0_cout = 1'($urandom); clb1_cout = 1'($urandom);
      applyStimulus(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                    2'($urandom), 1'($urandom), 1'($urandom));
      checkAll("rnd");
      step();
    end
    rst = 1'b0; cfg_valid = 1'b0; cfg_abort = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
